// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port memory with a shared tri-state data bus.
// Grant to done in ACCESS_CYCLES+1 cycles; requesters hold req until done, one access per ACCESS_CYCLES+2 cycles.
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  read_write,
  output logic                  enable,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  winner;
  logic                  last_grant;
  logic                  drive;
  logic                  pick;

  // The drive enable is a flop cleared by reset, so the bus is released asynchronously.
  assign data = drive ? lat_wdata : 'z;

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_grant;
    else              pick = ~req0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      drive      <= 1'b0;
      enable     <= 1'b0;
      read_write <= 1'b1;
      address    <= '0;
      busy       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner     <= pick;
            if (req0 && req1) last_grant <= pick;
            lat_we     <= pick ? we1 : we0;
            lat_wdata  <= pick ? wdata1 : wdata0;
            address    <= pick ? addr1 : addr0;
            read_write <= ~(pick ? we1 : we0);
            drive      <= pick ? we1 : we0;
            enable     <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            if (!lat_we) begin
              if (winner) rdata1 <= data;
              else        rdata0 <= data;
            end
            enable     <= 1'b0;
            drive      <= 1'b0;
            read_write <= 1'b1;
            done0      <= ~winner;
            done1      <= winner;
            state      <= TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TURN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a random run against a transaction-level schedule model.
module tb_mem_arbiter;
  localparam int AC = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset, preload;
  logic req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic done0, done1, busy, read_write, enable;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] address;
  wire  [DW-1:0] data;

  mem_arbiter #(.ACCESS_CYCLES(AC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .busy(busy), .read_write(read_write), .enable(enable), .address(address), .data(data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(int i);
    if (i == 16) return 16'hBEEF;
    return (16'(i) * 16'h0101) ^ 16'h3C00;
  endfunction

  // Memory device: drives reads; holds the bus at 0 when disabled so any stray arbiter drive is visible.
  logic [DW-1:0] mem [0:255];
  assign data = !enable ? '0 : (read_write ? mem[address[7:0]] : 'z);
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (enable && !read_write) begin
      mem[address[7:0]] <= data;
    end
  end

  // Reference: each grant at edge g gives enable on edges g..g+AC-1, done at g+AC, free again at g+AC+2.
  logic [DW-1:0] ref_mem [0:255];
  int            e;
  bit            m_act;
  int            m_g, m_win, m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd [2];
  bit            seen_done [2];
  int            vectors, miscompares;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_last = 1; m_rd[0] = '0; m_rd[1] = '0;
    seen_done[0] = 0; seen_done[1] = 0;
  endtask

  task automatic predict();
    int w;
    if (!reset && (!m_act || (e + 1 - m_g) >= AC + 2) && (req0 || req1)) begin
      if (req0 && req1) begin
        w = (m_last == 0) ? 1 : 0;
        m_last = w;
      end else begin
        w = req0 ? 0 : 1;
      end
      m_act   = 1;
      m_g     = e + 1;
      m_win   = w;
      m_we    = w ? we1 : we0;
      m_addr  = w ? addr1 : addr0;
      m_wdata = w ? wdata1 : wdata0;
    end
  endtask

  task automatic check();
    int off;
    bit en_x, busy_x, done_x;
    off    = e - m_g;
    en_x   = m_act && off < AC;
    busy_x = m_act && off <= AC;
    done_x = m_act && off == AC;
    if (done_x) begin
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      else      m_rd[m_win] = ref_mem[m_addr[7:0]];
      seen_done[m_win] = 1;
    end
    chk("enable", enable, en_x);
    chk("busy", busy, busy_x);
    chk("done0", done0, done_x && m_win == 0);
    chk("done1", done1, done_x && m_win == 1);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    if (en_x) begin
      chk("address", address, m_addr);
      chk("read_write", read_write, !m_we);
      chk("data_access", data, m_we ? m_wdata : ref_mem[m_addr[7:0]]);
    end else begin
      chk("read_write_idle", read_write, 1);
      chk("data_released", data, 0);
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    e++;
    check();
  endtask

  task automatic wait_done(int p, output int nt);
    nt = 0;
    seen_done[p] = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nt++;
      if (seen_done[p]) break;
    end
    chk("wait_done", seen_done[p], 1);
    seen_done[p] = 0;
  endtask

  task automatic set_port(int p, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic new_req(int p);
    set_port(p, 1'b1, 1'($urandom_range(1, 0)), 16'h0020 + 16'($urandom_range(15, 0)), 16'($urandom));
  endtask

  task automatic drop(int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic drive_port(int p);
    bit pend, gr;
    pend = (p == 0) ? req0 : req1;
    gr   = m_act && m_win == p && (e - m_g) <= AC;
    if (seen_done[p]) begin
      seen_done[p] = 0;
      if ($urandom_range(1, 0) == 1) new_req(p);
      else drop(p);
    end else if (!pend) begin
      if ($urandom_range(2, 0) == 0) new_req(p);
    end else if (gr) begin
      // Fields are latched at grant; wiggling them must not disturb the access.
      if ($urandom_range(3, 0) == 0) set_port(p, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    end else if ($urandom_range(19, 0) == 0) begin
      drop(p);
    end
  endtask

  int nt, n, first;
  int ord [7];
  int edg [7];

  initial begin
    reset = 1'b0; preload = 1'b1;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    vectors = 0; miscompares = 0; e = 0; m_g = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    model_reset();

    #1 reset = 1'b1;
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_read_write", read_write, 1);
    chk("rst_address", address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_data", data, 0);
    repeat (3) tick();
    preload = 1'b0;
    #2 reset = 1'b0;
    tick();

    // Single read, port 0
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    wait_done(0, nt);
    drop(0);
    chk("t1_latency", nt, AC + 1);
    chk("t1_rdata0", rdata0, 16'hBEEF);
    repeat (2) tick();

    // Write then back-to-back read, port 1
    set_port(1, 1, 1, 16'h00FF, 16'h1234);
    wait_done(1, nt);
    we1 = 1'b0;
    wait_done(1, nt);
    drop(1);
    chk("t2_b2b_spacing", nt, AC + 2);
    chk("t2_rdata1", rdata1, 16'h1234);
    chk("t2_rdata0_kept", rdata0, 16'hBEEF);
    repeat (2) tick();

    // Conflict: both held, completions must alternate starting with port 0
    set_port(0, 1, 0, 16'h0020, 16'h0000);
    set_port(1, 1, 0, 16'h0021, 16'h0000);
    n = 0;
    for (int i = 0; i < 60 && n < 7; i++) begin
      tick();
      chk("t3_not_both", done0 && done1, 0);
      if (done0 || done1) begin
        ord[n] = done1 ? 1 : 0;
        edg[n] = e;
        n++;
      end
    end
    drop(0); drop(1);
    seen_done[0] = 0; seen_done[1] = 0;
    chk("t3_count", n, 7);
    for (int i = 0; i < n; i++) begin
      chk("t3_order", ord[i], i % 2);
      if (i > 0) chk("t3_spacing", edg[i] - edg[i-1], AC + 2);
    end
    repeat (2) tick();

    // Back-to-back reads on port 0 with new address after each done
    set_port(0, 1, 0, 16'h0001, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      wait_done(0, nt);
      chk("t4_rdata0", rdata0, seed(k));
      chk("t4_spacing", nt, (k == 1) ? AC + 1 : AC + 2);
      addr0 = 16'(k + 1);
    end
    drop(0);
    repeat (2) tick();

    // Reset during the second access cycle of a port-1 write
    set_port(1, 1, 1, 16'h00F0, 16'hA55A);
    tick();
    tick();
    chk("t5_mid_write", data, 16'hA55A);
    drop(1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t5_enable", enable, 0);
    chk("t5_data", data, 0);
    chk("t5_done1", done1, 0);
    chk("t5_busy", busy, 0);
    tick();
    tick();
    #2 reset = 1'b0;
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    set_port(1, 1, 0, 16'h0011, 16'h0000);
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      tick();
      if (done0 || done1) first = done1 ? 1 : 0;
    end
    drop(0);
    chk("t5_first_port", first, 0);
    wait_done(1, nt);
    drop(1);
    repeat (2) tick();

    // Random traffic on both ports
    seen_done[0] = 0; seen_done[1] = 0;
    for (int c = 0; c < 1000; c++) begin
      drive_port(0);
      drive_port(1);
      tick();
    end
    drop(0); drop(1);
    repeat (AC + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared single-port memory_bidi (16-bit address, 16-bit bidirectional data, read_write/enable control).
- Port 0 is the instruction-fetch requester; port 1 is the load/store requester.
- Grants the memory to one port at a time (round-robin on conflict) and sequences each access: address/control phase, data phase, bus turnaround.
- Owns the arbiter side of the tri-state data bus.

Parameters:
- ACCESS_CYCLES, 2, cycles enable/address/read_write are held per access (>=1); read data is captured on the last one
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 16, data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0  in  1  port 0 request
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_WIDTH  port 0 address
- wdata0  in  DATA_WIDTH  port 0 write data
- done0  out  1  port 0 completion pulse
- rdata0  out  DATA_WIDTH  port 0 read data
- req1, we1, addr1, wdata1, done1, rdata1  same as port 0, for port 1
- busy  out  1  high while an access is in progress (ACCESS or TURN)
- read_write  out  1  to memory: 1 = read, 0 = write
- enable  out  1  to memory: access enable
- address  out  ADDR_WIDTH  to memory
- data  inout  DATA_WIDTH  shared memory data bus

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high. Asserting reset immediately forces:
  - state=IDLE, enable=0, read_write=1, address=0, data=Z
  - done0=done1=0, rdata0=rdata1=0, busy=0, last_grant=1 (port 0 wins the first conflict)
- States:
  - IDLE: if any req is sampled high at the clk edge, latch the winner's we/addr/wdata and go to ACCESS with cnt=0.
    - Arbitration: only one requesting -> that port wins. Both requesting -> the port != last_grant wins, and last_grant is updated to the winner.
  - ACCESS:
    - Outputs: enable=1, address=latched addr, read_write=~latched we.
    - data is driven with latched wdata only when the access is a write; otherwise it is Z.
    - cnt increments each cycle. When cnt==ACCESS_CYCLES-1: for a read, capture data into the winner's rdata; then go to TURN.
  - TURN:
    - Outputs: enable=0, data=Z, read_write=1.
    - The winner's done pulses high for exactly this one cycle.
    - Next state is IDLE. No request is accepted in TURN (guaranteed turnaround, no bus contention).
- Latency: req sampled at edge k -> enable high on cycles k+1..k+ACCESS_CYCLES -> done high on cycle k+ACCESS_CYCLES+1. Throughput is one access per ACCESS_CYCLES+2 cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees done. Fields are latched at grant, so later changes do not affect the current access.
  - A req still high in the cycle after done is treated as a new request (back-to-back).
  - A req dropped before grant is never serviced and produces no done.
- rdata0/rdata1 are registered and hold their value until the next read completion on that port; writes leave rdata unchanged.
- address keeps its last value outside ACCESS.
- done0 and done1 are never high together. enable and write-drive of data never overlap TURN or IDLE.
- Reset mid-access aborts the access: no done pulse, no rdata update, bus released asynchronously.
- cnt width is clog2(ACCESS_CYCLES)+1. With ACCESS_CYCLES=1, ACCESS lasts a single cycle.

Test Plan:
- Single read, port 0: mem[0x0010]=0xBEEF; req0 read addr0=0x0010 -> enable high 2 cycles with read_write=1 and address=0x0010; done0 one cycle later; rdata0=0xBEEF; done1 stays 0.
- Single write then read, port 1: write 0x1234 to 0x00FF -> data bus=0x1234 only while enable=1, Z in TURN; a following read returns 0x1234 on rdata1 with rdata0 unchanged.
- Conflict fairness: req0 and req1 held continuously, both reads -> completions alternate 0,1,0,1 starting with port 0; each done is 4 cycles apart; never simultaneous.
- Back-to-back same port: req0 held for 3 reads at 0x0001..0x0003 (addr changed after each done) -> 3 done0 pulses exactly 4 cycles apart, with correct rdata0 each time.
- Reset mid-access: assert reset during the second ACCESS cycle of a port-1 write -> enable=0 and data=Z immediately, no done1; after release, req0 read is serviced first (last_grant reset to 1).
- Bus contention check: a monitor flags any cycle where the arbiter drives data while read_write=1 or enable=0 -> zero violations over a 1000-cycle random req/we run.
